// File: rtl/ucode_sequencer.sv
// ucode_sequencer: microcode sequencer for the CPU control unit.
//
// Accepts opcodes from decode and looks up each microroutine entry point in an
// external 256x8 jump ROM that has a 1-cycle registered read. The micro-PC is
// then stepped through the control store according to the sequencing field of
// the microinstruction at upc. At each dispatch point a pending interrupt is
// taken ahead of the next opcode.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   op_valid_i     decode presents an opcode
//   op_i           opcode
//   op_ready_o     opcode accepted when op_valid_i && op_ready_o
//   jrom_adr_o     jump ROM address, combinationally equal to op_i
//   jrom_dout_i    jump ROM data, valid the cycle after the address is sampled
//   uctl_next_i    sequencing field: 00 SEQ, 01 BR, 10 DISP, 11 COND
//   uctl_target_i  branch target of the microinstruction at upc
//   cond_i         branch condition used by COND
//   stall_i        freeze the sequencer this cycle (ignored during lookup)
//   irq_req_i      interrupt pending (level)
//   irq_ack_o      one-cycle pulse when an interrupt is taken
//   upc_o          current micro-PC (registered)
//   upc_valid_o    upc_o addresses a live microinstruction
module ucode_sequencer #(
  parameter int unsigned          UADDR_W = 8,
  parameter int unsigned          OP_W    = 8,
  parameter logic [UADDR_W-1:0]   IRQ_VEC = 8'hF0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               op_valid_i,
  input  logic [OP_W-1:0]    op_i,
  output logic               op_ready_o,
  output logic [OP_W-1:0]    jrom_adr_o,
  input  logic [UADDR_W-1:0] jrom_dout_i,
  input  logic [1:0]         uctl_next_i,
  input  logic [UADDR_W-1:0] uctl_target_i,
  input  logic               cond_i,
  input  logic               stall_i,
  input  logic               irq_req_i,
  output logic               irq_ack_o,
  output logic [UADDR_W-1:0] upc_o,
  output logic               upc_valid_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLookup = 2'b01,
    StRun    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SeqNext  = 2'b00,
    SeqBr    = 2'b01,
    SeqDisp  = 2'b10,
    SeqCond  = 2'b11
  } seq_e;

  state_e               state_q, state_d;
  logic [UADDR_W-1:0]   upc_q, upc_d;
  logic                 upc_valid_q, upc_valid_d;
  logic                 irq_ack_q, irq_ack_d;

  seq_e                 seq;
  logic                 dispatch;
  logic [UADDR_W-1:0]   upc_inc;

  assign seq     = seq_e'(uctl_next_i);
  assign upc_inc = upc_q + UADDR_W'(1);

  // The ROM samples this address on the same edge that accepts the opcode.
  assign jrom_adr_o = op_i;

  // A dispatch point is either an idle sequencer or an unstalled DISP in RUN.
  always_comb begin
    dispatch = 1'b0;
    if (state_q == StIdle) begin
      dispatch = 1'b1;
    end else if (state_q == StRun && seq == SeqDisp && !stall_i) begin
      dispatch = 1'b1;
    end
  end

  // Interrupts win at a dispatch point, so the opcode is held off while one is pending.
  assign op_ready_o = dispatch && !irq_req_i;

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    upc_valid_d = upc_valid_q;
    irq_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        upc_valid_d = 1'b0;
        if (irq_req_i) begin
          upc_d       = IRQ_VEC;
          upc_valid_d = 1'b1;
          irq_ack_d   = 1'b1;
          state_d     = StRun;
        end else if (op_valid_i) begin
          state_d = StLookup;
        end
      end

      // Stall is deliberately ignored: the ROM output is only valid this cycle.
      StLookup: begin
        upc_d       = jrom_dout_i;
        upc_valid_d = 1'b1;
        state_d     = StRun;
      end

      StRun: begin
        if (!stall_i) begin
          unique case (seq)
            SeqNext: upc_d = upc_inc;
            SeqBr:   upc_d = uctl_target_i;
            SeqCond: upc_d = cond_i ? uctl_target_i : upc_inc;
            SeqDisp: begin
              if (irq_req_i) begin
                upc_d     = IRQ_VEC;
                irq_ack_d = 1'b1;
              end else if (op_valid_i) begin
                upc_valid_d = 1'b0;
                state_d     = StLookup;
              end else begin
                upc_valid_d = 1'b0;
                state_d     = StIdle;
              end
            end
            default: upc_d = upc_q;
          endcase
        end
      end

      default: begin
        state_d     = StIdle;
        upc_valid_d = 1'b0;
      end
    endcase
  end

  // Reset drops to IDLE, which also discards any ROM read still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      upc_q       <= '0;
      upc_valid_q <= 1'b0;
      irq_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      upc_valid_q <= upc_valid_d;
      irq_ack_q   <= irq_ack_d;
    end
  end

  assign upc_o       = upc_q;
  assign upc_valid_o = upc_valid_q;
  assign irq_ack_o   = irq_ack_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios followed by a random phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_ucode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [7:0] op = 8'h00;
  logic       op_ready;
  logic [7:0] jrom_adr;
  logic [7:0] jrom_dout = 8'h00;
  logic [1:0] uctl_next = 2'b00;
  logic [7:0] uctl_target = 8'h00;
  logic       cond = 1'b0;
  logic       stall = 1'b0;
  logic       irq_req = 1'b0;
  logic       irq_ack;
  logic [7:0] upc;
  logic       upc_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom [256];

  // Reference model: the micro-PC, whether it is live, a queue of entry points
  // fetched from the ROM but not yet loaded, and the expected ack pulse.
  logic [7:0] m_upc;
  bit         m_live;
  logic [7:0] m_fetch [$];
  bit         m_ack;

  ucode_sequencer #(
    .UADDR_W (8),
    .OP_W    (8),
    .IRQ_VEC (8'hF0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_valid_i    (op_valid),
    .op_i          (op),
    .op_ready_o    (op_ready),
    .jrom_adr_o    (jrom_adr),
    .jrom_dout_i   (jrom_dout),
    .uctl_next_i   (uctl_next),
    .uctl_target_i (uctl_target),
    .cond_i        (cond),
    .stall_i       (stall),
    .irq_req_i     (irq_req),
    .irq_ack_o     (irq_ack),
    .upc_o         (upc),
    .upc_valid_o   (upc_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) jrom_dout <= rom[jrom_adr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_live && m_fetch.size() == 0;
  endfunction

  function automatic bit m_ready(input bit ov_unused);
    bit at_dispatch;
    at_dispatch = m_idle() || (m_live && m_fetch.size() == 0 && uctl_next == 2'd2 && !stall);
    return at_dispatch && !irq_req;
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic m_edge();
    m_ack = 1'b0;
    if (m_fetch.size() != 0) begin
      m_upc  = m_fetch.pop_front();
      m_live = 1'b1;
    end else if (!m_live) begin
      if (irq_req) begin
        m_upc  = 8'hF0;
        m_live = 1'b1;
        m_ack  = 1'b1;
      end else if (op_valid) begin
        m_fetch.push_back(rom[op]);
      end
    end else if (!stall) begin
      case (uctl_next)
        2'd0: m_upc = m_upc + 8'd1;
        2'd1: m_upc = uctl_target;
        2'd3: m_upc = cond ? uctl_target : m_upc + 8'd1;
        default: begin
          if (irq_req) begin
            m_upc = 8'hF0;
            m_ack = 1'b1;
          end else begin
            m_live = 1'b0;
            if (op_valid) m_fetch.push_back(rom[op]);
          end
        end
      endcase
    end
  endtask

  function automatic void m_reset();
    m_upc  = 8'h00;
    m_live = 1'b0;
    m_ack  = 1'b0;
    m_fetch.delete();
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".upc"},       upc,       m_upc);
    chk({tag, ".upc_valid"}, upc_valid, m_live);
    chk({tag, ".irq_ack"},   irq_ack,   m_ack);
  endtask

  // One cycle: drive inputs, check op_ready before the edge, check state after it.
  task automatic step(input string tag, input bit ov, input logic [7:0] o,
                      input logic [1:0] nx, input logic [7:0] tg, input bit c,
                      input bit st, input bit irq);
    op_valid    = ov;
    op          = o;
    uctl_next   = nx;
    uctl_target = tg;
    cond        = c;
    stall       = st;
    irq_req     = irq;
    #1;
    chk({tag, ".op_ready"}, op_ready, m_ready(ov));
    chk({tag, ".jrom_adr"}, jrom_adr, o);
    @(posedge clk);
    m_edge();
    #1;
    check_outs(tag);
  endtask

  // Reset asserted between edges, held over one edge, released between edges.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_outs({tag, ".async"});
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outs({tag, ".held"});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h3A] = 8'h40;
    rom[8'h00] = 8'h10;
    m_reset();

    // T1: reset state, then an opcode through the lookup.
    #12;
    check_outs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("t1.accept", 1, 8'h3A, 2'd0, 8'h00, 0, 0, 0);
    chk("t1.lookup_valid", upc_valid, 1'b0);
    step("t1.load", 0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t1.entry", upc, 8'h40);

    // T2: SEQ, SEQ, BR, COND not taken, COND taken.
    step("t2.seq1",  0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t2.41", upc, 8'h41);
    step("t2.seq2",  0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    step("t2.br",    0, 8'h00, 2'd1, 8'h55, 0, 0, 0);
    chk("t2.55", upc, 8'h55);
    step("t2.cond0", 0, 8'h00, 2'd3, 8'h99, 0, 0, 0);
    chk("t2.56", upc, 8'h56);
    step("t2.cond1", 0, 8'h00, 2'd3, 8'h20, 1, 0, 0);
    chk("t2.20", upc, 8'h20);

    // T3: micro-PC wraps from FF to 00.
    step("t3.br",  0, 8'h00, 2'd1, 8'hFF, 0, 0, 0);
    step("t3.seq", 0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t3.wrap", upc, 8'h00);
    chk("t3.valid", upc_valid, 1'b1);

    // T4: interrupt beats the opcode at a dispatch, then the opcode goes through.
    step("t4.disp_irq", 1, 8'h00, 2'd2, 8'h00, 0, 0, 1);
    chk("t4.vec", upc, 8'hF0);
    chk("t4.ack", irq_ack, 1'b1);
    step("t4.isr", 1, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t4.ack_drop", irq_ack, 1'b0);
    step("t4.disp_op", 1, 8'h00, 2'd2, 8'h00, 0, 0, 0);
    step("t4.lookup_stall", 0, 8'h00, 2'd0, 8'h00, 0, 1, 0);
    chk("t4.entry", upc, 8'h10);

    // T5: stall freezes RUN, release resumes.
    step("t5.br", 0, 8'h00, 2'd1, 8'h42, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t5.stall", 1, 8'h3A, 2'd2, 8'h00, 0, 1, 1);
    chk("t5.hold", upc, 8'h42);
    step("t5.go", 0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t5.43", upc, 8'h43);

    // T6: reset in the middle of a lookup discards the ROM result.
    step("t6.disp", 1, 8'h3A, 2'd2, 8'h00, 0, 0, 0);
    mid_reset("t6");
    step("t6.after", 0, 8'h00, 2'd0, 8'h00, 0, 0, 0);
    chk("t6.no_load", upc_valid, 1'b0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rop;
      rop = ($urandom_range(0, 3) == 0) ? 8'h3A : 8'($urandom);
      step("rnd",
           $urandom_range(0, 2) != 0, rop, 2'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) mid_reset("rnd.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
